octant_mirror_pipe: RTL and testbench
=====================================

OCTANT_MIRROR_PIPE -- requirements
Module: octant_mirror_pipe

Interface
REQ-001 Parameters (name, default, meaning):
- W, 16: data width of XM, YM, sin_amp, cos_amp.
- SHIFT, 1: right shift applied to the selected magnitude, range 0..W-1.
- ROUND, 0: 0 = truncate on shift; 1 = round-half-up on shift.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- XM, in, W: unsigned CORDIC X magnitude.
- YM, in, W: unsigned CORDIC Y magnitude.
- index_qua, in, 3: octant code accompanying XM/YM.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts a beat this cycle.
- sin_amp, out, W: signed sine amplitude.
- cos_amp, out, W: signed cosine amplitude.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the output beat.
- sat_flag, out, 1: sticky saturation indicator.
- sat_clr, in, 1: synchronous clear of sat_flag.

Function
REQ-003 A beat SHALL be accepted on a rising clk edge when in_valid=1 and in_ready=1.
REQ-004 The block SHALL be a two-stage pipeline:
- Stage 1 registers the selected, shifted and rounded magnitudes plus the sign controls.
- Stage 2 registers the negated and saturated results.
- Latency from acceptance to out_valid=1 SHALL be exactly 2 cycles when out_ready=1.
REQ-005 Advance enables: en2 = ~v2 | out_ready; en1 = ~v1 | en2; in_ready = en1 (combinational). With out_ready=1 the throughput SHALL be one beat per cycle.
REQ-006 A stalled stage (enable low) SHALL hold its data and valid bit; sin_amp, cos_amp and out_valid SHALL remain stable until the beat is consumed (out_valid & out_ready).
REQ-007 Component and sign selection:
- swap = index_qua[0]^index_qua[1].
- sin source = swap ? YM : XM; cos source = the other input.
- sin_neg = index_qua[1]^index_qua[2]; cos_neg = index_qua[2].
REQ-008 Magnitude computation:
- m = source >> SHIFT, zero-extended.
- When ROUND=1, add bit (SHIFT-1) of the source before the shift; ROUND has no effect when SHIFT=0.
REQ-009 Saturation: if m > 2^(W-1)-1, then m = 2^(W-1)-1 and sat_flag SHALL set on the stage-2 load of that beat.
REQ-010 Negation: the result is two's-complement -m when the neg control is 1, otherwise m. -0 SHALL yield 0. The result SHALL never equal -2^(W-1).
REQ-011 When stage 2 holds no valid beat, sin_amp and cos_amp SHALL be driven 0 (bubble zeroing).
REQ-012 sat_flag SHALL stay set until a cycle with sat_clr=1. If a set and a clear occur in the same cycle, set SHALL win.

Reset
REQ-013 While reset=0, the following SHALL be cleared asynchronously: v1, v2, out_valid, sin_amp, cos_amp, sat_flag, and all stage data.
REQ-014 in_ready SHALL read 1 during reset. Beats in flight when reset asserts SHALL be discarded and never appear on the output.
REQ-015 The first beat accepted after reset deasserts SHALL appear after 2 cycles.

Configuration
REQ-016 Macro MIRROR_COS_EN:
- Defined: the cos path SHALL exist exactly as specified above.
- Undefined: the cos path logic SHALL be omitted, cos_amp SHALL be tied to 0, and sat_flag SHALL reflect the sin path only. The port list SHALL be unchanged.

Verification (W=16, SHIFT=1, ROUND=0, MIRROR_COS_EN defined unless stated)
REQ-017 Basic path: XM=16'h8000, YM=16'h4000, index_qua=000, out_ready=1 -> 2 cycles later sin_amp=16'h4000, cos_amp=16'h2000, out_valid=1.
REQ-018 Octant mapping, same inputs:
- index_qua=011 -> sin_amp=16'hC000, cos_amp=16'h2000.
- index_qua=001 -> sin_amp=16'h2000, cos_amp=16'h4000.
- index_qua=110 -> sin_amp=16'h2000, cos_amp=16'hC000.
REQ-019 Rounding and saturation:
- ROUND=1, XM=16'h0003, index_qua=000 -> sin_amp=16'h0002.
- SHIFT=0, XM=16'hFFFF, index_qua=010 -> sin_amp=16'h8001 and sat_flag=1; sat_clr pulse -> sat_flag=0.
REQ-020 Backpressure: out_ready=0, three back-to-back valid beats offered -> first two accepted, in_ready=0 on the third; output holds beat 1. Raising out_ready -> beats 1, 2, 3 delivered in order with no loss or duplication.
REQ-021 Reset mid-operation: assert reset with both stages full -> out_valid=0, sin_amp=0, cos_amp=0, sat_flag=0 immediately; no stale beat after release.
REQ-022 Bubble and macro: in_valid=0 -> sin_amp=cos_amp=0 with out_valid=0. With MIRROR_COS_EN undefined, the REQ-017 stimulus -> cos_amp=0, sin_amp=16'h4000.

Source files
------------

// File: rtl/octant_mirror_pipe.sv
// Octant mirror pipeline: maps CORDIC first-octant magnitudes (XM, YM) to signed
// sine/cosine amplitudes for the octant given by index_qua. The magnitudes are
// shifted, optionally rounded, saturated and negated over a two-stage
// valid/ready pipeline.
//
// Optional feature macro: MIRROR_COS_EN
//   defined   - cosine path present
//   undefined - cosine path omitted, cos_amp tied to 0, sat_flag from sine only
//
// Ports:
//   clk, reset (async, active-low)
//   XM, YM, index_qua, in_valid, in_ready : input beat (in_ready is combinational)
//   sin_amp, cos_amp, out_valid, out_ready: output beat (registered)
//   sat_flag, sat_clr                     : sticky saturation flag and its clear
module octant_mirror_pipe #(
    parameter int unsigned W     = 16,
    parameter int unsigned SHIFT = 1,
    parameter int unsigned ROUND = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] XM,
    input  logic [W-1:0] YM,
    input  logic [2:0]   index_qua,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] sin_amp,
    output logic [W-1:0] cos_amp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sat_flag,
    input  logic         sat_clr
);

    // Bit added for round-half-up; clamped so SHIFT=0 never indexes bit -1.
    localparam int unsigned RBIT = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    // Shift with optional rounding; one extra bit absorbs the rounding carry.
    function automatic logic [W-1:0] scale(input logic [W-1:0] src);
        logic [W:0] ext;
        ext = {1'b0, src};
        if (ROUND != 0 && SHIFT != 0) begin
            ext = ext + (W+1)'(src[RBIT]);
        end
        return W'(ext >> SHIFT);
    endfunction

    // Clamp to the positive maximum, then apply the sign. Clamping first keeps
    // the result away from the most negative code and makes -0 equal 0.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] m, input logic neg);
        logic [W-1:0] mag;
        mag = m[W-1] ? MAX_POS : m;
        return neg ? (~mag + W'(1)) : mag;
    endfunction

    logic         en1;
    logic         en2;
    logic         swap;
    logic         v1;
    logic         v2;
    logic [W-1:0] sin_m1;
    logic         sin_neg1;
    logic         cos_hit;
    logic         sat_set;

    // Pipeline advance enables.
    always_comb begin
        en2      = ~v2 | out_ready;
        en1      = ~v1 | en2;
        in_ready = en1;
        swap     = index_qua[0] ^ index_qua[1];
    end

    assign out_valid = v2;

    // Stage 1: sine magnitude and sign control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1       <= 1'b0;
            sin_m1   <= '0;
            sin_neg1 <= 1'b0;
        end else if (en1) begin
            v1       <= in_valid;
            sin_m1   <= scale(swap ? YM : XM);
            sin_neg1 <= index_qua[1] ^ index_qua[2];
        end
    end

    // Stage 2: sine result, zeroed when a bubble advances into it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2      <= 1'b0;
            sin_amp <= '0;
        end else if (en2) begin
            v2      <= v1;
            sin_amp <= v1 ? sat_neg(sin_m1, sin_neg1) : '0;
        end
    end

`ifdef MIRROR_COS_EN
    logic [W-1:0] cos_m1;
    logic         cos_neg1;

    // Stage 1: cosine magnitude and sign control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cos_m1   <= '0;
            cos_neg1 <= 1'b0;
        end else if (en1) begin
            cos_m1   <= scale(swap ? XM : YM);
            cos_neg1 <= index_qua[2];
        end
    end

    // Stage 2: cosine result, zeroed on bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cos_amp <= '0;
        end else if (en2) begin
            cos_amp <= v1 ? sat_neg(cos_m1, cos_neg1) : '0;
        end
    end

    assign cos_hit = cos_m1[W-1];
`else
    assign cos_amp = '0;
    assign cos_hit = 1'b0;
`endif

    // A valid beat saturates when its magnitude has the sign bit set.
    assign sat_set = en2 & v1 & (sin_m1[W-1] | cos_hit);

    // Sticky saturation flag; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= sat_set | (sat_flag & ~sat_clr);
        end
    end

endmodule

// File: tb/tb_octant_mirror_pipe.sv
// Directed testbench for octant_mirror_pipe. Three instances share all inputs:
// u_dut (SHIFT=1, ROUND=0), u_rnd (SHIFT=1, ROUND=1) and u_sh0 (SHIFT=0).
// Expected cosine values depend on whether MIRROR_COS_EN is defined.
module tb_octant_mirror_pipe;

`ifdef MIRROR_COS_EN
    localparam bit COS_EN = 1'b1;
`else
    localparam bit COS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] xm;
    logic [15:0] ym;
    logic [2:0]  q;
    logic        in_valid;
    logic        out_ready;
    logic        sat_clr;

    logic [15:0] sin_d, cos_d, sin_r, cos_r, sin_s, cos_s;
    logic        ir_d, ir_r, ir_s;
    logic        ov_d, ov_r, ov_s;
    logic        sat_d, sat_r, sat_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    octant_mirror_pipe #(.W(16), .SHIFT(1), .ROUND(0)) u_dut (
        .clk(clk), .reset(reset), .XM(xm), .YM(ym), .index_qua(q),
        .in_valid(in_valid), .in_ready(ir_d), .sin_amp(sin_d), .cos_amp(cos_d),
        .out_valid(ov_d), .out_ready(out_ready), .sat_flag(sat_d), .sat_clr(sat_clr)
    );

    octant_mirror_pipe #(.W(16), .SHIFT(1), .ROUND(1)) u_rnd (
        .clk(clk), .reset(reset), .XM(xm), .YM(ym), .index_qua(q),
        .in_valid(in_valid), .in_ready(ir_r), .sin_amp(sin_r), .cos_amp(cos_r),
        .out_valid(ov_r), .out_ready(out_ready), .sat_flag(sat_r), .sat_clr(sat_clr)
    );

    octant_mirror_pipe #(.W(16), .SHIFT(0), .ROUND(0)) u_sh0 (
        .clk(clk), .reset(reset), .XM(xm), .YM(ym), .index_qua(q),
        .in_valid(in_valid), .in_ready(ir_s), .sin_amp(sin_s), .cos_amp(cos_s),
        .out_valid(ov_s), .out_ready(out_ready), .sat_flag(sat_s), .sat_clr(sat_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [2:0] oc);
        xm       = x;
        ym       = y;
        q        = oc;
        in_valid = 1'b1;
    endtask

    function automatic logic [15:0] ecos(input logic [15:0] v);
        return COS_EN ? v : 16'h0000;
    endfunction

    // One beat into an idle pipe: nothing after the accept edge, result one edge later.
    task automatic send(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [2:0] oc, input logic [15:0] es, input logic [15:0] ec);
        drive(x, y, oc);
        tick;
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(ov_d), 32'(0));
        tick;
        check({tag, "_ov"}, 32'(ov_d), 32'(1));
        check({tag, "_sin"}, 32'(sin_d), 32'(es));
        check({tag, "_cos"}, 32'(cos_d), 32'(ecos(ec)));
    endtask

    initial begin
        reset     = 1'b0;
        xm        = '0;
        ym        = '0;
        q         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;

        #3;
        check("rst_ov",    32'(ov_d),  32'(0));
        check("rst_sin",   32'(sin_d), 32'(0));
        check("rst_cos",   32'(cos_d), 32'(0));
        check("rst_sat",   32'(sat_d), 32'(0));
        check("rst_ready", 32'(ir_d),  32'(1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // Octant mapping.
        send("oct000", 16'h8000, 16'h4000, 3'b000, 16'h4000, 16'h2000);
        send("oct011", 16'h8000, 16'h4000, 3'b011, 16'hC000, 16'h2000);
        send("oct001", 16'h8000, 16'h4000, 3'b001, 16'h2000, 16'h4000);
        send("oct110", 16'h8000, 16'h4000, 3'b110, 16'h2000, 16'hC000);

        // Bubble zeroing.
        tick;
        check("bub_ov",  32'(ov_d),  32'(0));
        check("bub_sin", 32'(sin_d), 32'(0));
        check("bub_cos", 32'(cos_d), 32'(0));

        // Truncate vs round-half-up.
        send("trunc3", 16'h0003, 16'h0000, 3'b000, 16'h0001, 16'h0000);
        check("round3_sin", 32'(sin_r), 32'(16'h0002));
        send("trunc56", 16'h0005, 16'h0006, 3'b000, 16'h0002, 16'h0003);
        check("round56_sin", 32'(sin_r), 32'(16'h0003));
        check("round56_cos", 32'(cos_r), 32'(ecos(16'h0003)));

        // Saturation: SHIFT=0 clamps, SHIFT=1 lands exactly on the maximum.
        send("max7fff", 16'hFFFF, 16'hFFFF, 3'b010, 16'h8001, 16'h7FFF);
        check("max7fff_nosat", 32'(sat_d), 32'(0));
        check("sat_sin",  32'(sin_s), 32'(16'h8001));
        check("sat_cos",  32'(cos_s), 32'(ecos(16'h7FFF)));
        check("sat_flag", 32'(sat_s), 32'(1));
        tick;
        check("sat_sticky", 32'(sat_s), 32'(1));
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0;
        check("sat_clr", 32'(sat_s), 32'(0));

        // Cosine-only saturation, with a negated zero on the sine side.
        send("negzero", 16'h0000, 16'hFFFF, 3'b011, 16'h0000, 16'h7FFF);
        check("cossat_sin",  32'(sin_s), 32'(0));
        check("cossat_flag", 32'(sat_s), 32'(COS_EN));
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0;
        check("cossat_clr", 32'(sat_s), 32'(0));

        // Set wins over a same-cycle clear.
        drive(16'hFFFF, 16'hFFFF, 3'b000);
        tick;
        in_valid = 1'b0;
        sat_clr  = 1'b1;
        tick;
        sat_clr  = 1'b0;
        check("set_wins", 32'(sat_s), 32'(1));
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0;

        // Backpressure: two beats fill the pipe, the third is refused.
        out_ready = 1'b0;
        drive(16'h0010, 16'h0002, 3'b000);
        #1 check("bp_rdy1", 32'(ir_d), 32'(1));
        tick;
        drive(16'h0020, 16'h0004, 3'b000);
        #1 check("bp_rdy2", 32'(ir_d), 32'(1));
        tick;
        check("bp_b1_ov",  32'(ov_d),  32'(1));
        check("bp_b1_sin", 32'(sin_d), 32'(16'h0008));
        drive(16'h0030, 16'h0006, 3'b000);
        #1 check("bp_rdy3", 32'(ir_d), 32'(0));
        tick;
        tick;
        check("bp_hold_sin", 32'(sin_d), 32'(16'h0008));
        check("bp_hold_cos", 32'(cos_d), 32'(ecos(16'h0001)));
        check("bp_hold_ov",  32'(ov_d),  32'(1));
        check("bp_hold_rdy", 32'(ir_d),  32'(0));
        out_ready = 1'b1;
        #1 check("bp_release_rdy", 32'(ir_d), 32'(1));
        tick;
        in_valid = 1'b0;
        check("bp_b2_sin", 32'(sin_d), 32'(16'h0010));
        check("bp_b2_cos", 32'(cos_d), 32'(ecos(16'h0002)));
        tick;
        check("bp_b3_sin", 32'(sin_d), 32'(16'h0018));
        check("bp_b3_ov",  32'(ov_d),  32'(1));
        tick;
        check("bp_drained", 32'(ov_d), 32'(0));

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 3'b000);
        tick;
        drive(16'h0040, 16'h0040, 3'b000);
        tick;
        in_valid = 1'b0;
        check("mid_full_ov",  32'(ov_s),  32'(1));
        check("mid_full_sat", 32'(sat_s), 32'(1));
        reset = 1'b0;
        #1;
        check("mid_ov",    32'(ov_d),  32'(0));
        check("mid_sin",   32'(sin_d), 32'(0));
        check("mid_cos",   32'(cos_d), 32'(0));
        check("mid_sat",   32'(sat_s), 32'(0));
        check("mid_ready", 32'(ir_d),  32'(1));
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick;
        check("post_rst_ov1", 32'(ov_d), 32'(0));
        tick;
        check("post_rst_ov2", 32'(ov_d), 32'(0));

        // First beat after reset.
        send("post_rst", 16'h8000, 16'h4000, 3'b000, 16'h4000, 16'h2000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
